// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and baud divisor helper.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_DATA    = 3'd2,
        ST_PARITY  = 3'd3,
        ST_STOP    = 3'd4,
        ST_BREAK   = 3'd5,
        ST_CLEANUP = 3'd6
    } state_t;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous input pin; reset value selects the idle level.
// Latency: 2 cycles. No backpressure.
module uart_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver, 8N1 by default, start+8 data+even parity+stop when UART_RX_PARITY_EN is defined.
// Latency: byte strobed one cycle after the stop-bit centre sample (plus 2-cycle synchroniser skew).
// No backpressure: the consumer must take rx_byte on the rx_dv strobe.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FREQUENCY = 10000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_serial,
    output logic       rx_dv,
    output logic [7:0] rx_byte,
    output logic       rx_active,
    output logic       rx_frame_err,
    output logic       rx_parity_err
);

    localparam int CLKS_PER_BIT = clks_per_bit(FREQUENCY, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int IDX_W        = $clog2(UART_DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(UART_DATA_BITS - 1);

    logic rx_s;

    uart_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (rx_serial),
        .sync_o  (rx_s)
    );

    state_t                    state_q,  state_d;
    logic [CNT_W-1:0]          cnt_q,    cnt_d;
    logic [IDX_W-1:0]          idx_q,    idx_d;
    logic [UART_DATA_BITS-1:0] shift_q,  shift_d;
    logic [UART_DATA_BITS-1:0] byte_q,   byte_d;
    logic                      dv_q,     dv_d;
    logic                      active_q, active_d;
    logic                      ferr_q,   ferr_d;
`ifdef UART_RX_PARITY_EN
    logic                      perr_flag_q, perr_flag_d;
    logic                      perr_q,      perr_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        active_d = active_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_flag_d = perr_flag_q;
        perr_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
`ifdef UART_RX_PARITY_EN
                perr_flag_d = 1'b0;
`endif
                if (!rx_s) begin
                    state_d  = ST_START;
                    active_d = 1'b1;
                end
            end
            ST_START: begin
                // Re-check the line at mid start bit to reject short glitches.
                if (cnt_q == CNT_HALF_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        state_d  = ST_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d       = '0;
                    perr_flag_d = (^shift_q) ^ rx_s;
                    state_d     = ST_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (cnt_q == CNT_BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = ST_CLEANUP;
`ifdef UART_RX_PARITY_EN
                        if (perr_flag_q) begin
                            perr_d = 1'b1;
                        end else begin
                            byte_d = shift_q;
                            dv_d   = 1'b1;
                        end
`else
                        byte_d = shift_q;
                        dv_d   = 1'b1;
`endif
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                // Hold here while the line stays low so a break cannot look like a new start bit.
                if (rx_s) begin
                    state_d  = ST_IDLE;
                    active_d = 1'b0;
                end
            end
            ST_CLEANUP: begin
                active_d = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                active_d = 1'b0;
                cnt_d    = '0;
                idx_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            active_q <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_flag_q <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            active_q <= active_d;
            ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_flag_q <= perr_flag_d;
            perr_q      <= perr_d;
`endif
        end
    end

    assign rx_dv        = dv_q;
    assign rx_byte      = byte_q;
    assign rx_active    = active_q;
    assign rx_frame_err = ferr_q;
`ifdef UART_RX_PARITY_EN
    assign rx_parity_err = perr_q;
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
